// File: rtl/round_demux_seq.sv
// Routes din to one of N_OUT channel registers, by sel (manual) or by an internal round counter (auto).
// Latency 1 cycle; din_ready drops outside manual IDLE and RUN, and while rst is high.
module round_demux_seq #(
  parameter int N_OUT  = 11,
  parameter int DATA_W = 128,
  parameter int SEL_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    start,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DATA_W-1:0]       din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [N_OUT*DATA_W-1:0] dout,
  output logic [N_OUT-1:0]        strobe,
  output logic [SEL_W-1:0]        round,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   round_nxt;
  logic [SEL_W-1:0]   wr_idx;
  logic               wr_en;
  logic               err_nxt;
  logic               accept;
  logic [N_OUT-1:0]   strobe_nxt;

  assign din_ready = !rst && ((state == IDLE && !mode) || state == RUN);
  assign accept    = din_valid && din_ready;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      round <= '0;
    end else begin
      state <= state_nxt;
      round <= round_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    round_nxt = round;
    wr_en     = 1'b0;
    wr_idx    = sel;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (mode) begin
          if (start) begin
            state_nxt = RUN;
            round_nxt = '0;
          end
        end else if (accept) begin
          // out-of-range selects are consumed but flagged instead of written
          if (sel <= LAST) wr_en   = 1'b1;
          else             err_nxt = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          wr_en  = 1'b1;
          wr_idx = round;
          if (round == LAST) begin
            state_nxt = DONE;
            round_nxt = '0;
          end else begin
            round_nxt = round + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    strobe_nxt = '0;
    for (int i = 0; i < N_OUT; i++)
      strobe_nxt[i] = wr_en && (wr_idx == SEL_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe <= '0;
      err    <= 1'b0;
    end else begin
      strobe <= strobe_nxt;
      err    <= err_nxt;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_chan
    logic [DATA_W-1:0] q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)               q <= '0;
      else if (strobe_nxt[g]) q <= din;
    end
    assign dout[g*DATA_W +: DATA_W] = q;
  end

endmodule

// File: tb/tb_round_demux_seq.sv
// Randomized bench for round_demux_seq against a transaction-level model of the channel map.
module tb_round_demux_seq;

  localparam int N  = 11;
  localparam int DW = 128;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode, start, din_valid;
  logic [SW-1:0]   sel;
  logic [DW-1:0]   din;
  logic            din_ready;
  logic [N*DW-1:0] dout;
  logic [N-1:0]    strobe;
  logic [SW-1:0]   round;
  logic            busy, done, err;

  round_demux_seq #(.N_OUT(N), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .sel(sel), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .dout(dout), .strobe(strobe),
    .round(round), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Model: a sequence is either not active, in progress (with a slot index), or just finished.
  logic [DW-1:0] m_chan [N];
  bit            m_in_seq;
  bit            m_finished;
  int            m_slot;
  logic [N-1:0]  m_strobe;
  bit            m_err;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_chan[i] = '0;
    m_in_seq = 0; m_finished = 0; m_slot = 0; m_strobe = '0; m_err = 0;
  endtask

  function automatic bit model_ready();
    return (!m_in_seq && !m_finished && !mode) || m_in_seq;
  endfunction

  task automatic check_outputs(input string ph);
    check({ph, "_strobe"}, DW'(strobe), DW'(m_strobe));
    check({ph, "_err"},    DW'(err),    DW'(m_err));
    check({ph, "_done"},   DW'(done),   DW'(m_finished));
    check({ph, "_busy"},   DW'(busy),   DW'(m_in_seq));
    check({ph, "_round"},  DW'(round),  DW'(m_slot));
    for (int i = 0; i < N; i++)
      check($sformatf("%s_ch%0d", ph, i), dout[i*DW +: DW], m_chan[i]);
  endtask

  // Apply inputs, check readiness, clock once, advance the model, check everything.
  task automatic cycle(input string ph, input bit md, input bit st, input bit vl,
                       input logic [SW-1:0] sl, input logic [DW-1:0] d);
    bit acc;
    mode = md; start = st; din_valid = vl; sel = sl; din = d;
    #1;
    check({ph, "_ready"}, DW'(din_ready), DW'(model_ready()));
    acc = vl && model_ready();
    @(posedge clk); #1;
    m_strobe = '0; m_err = 0;
    if (m_finished) begin
      m_finished = 0;
    end else if (m_in_seq) begin
      if (acc) begin
        m_chan[m_slot] = d;
        m_strobe[m_slot] = 1'b1;
        m_slot = m_slot + 1;
        if (m_slot == N) begin
          m_slot = 0; m_in_seq = 0; m_finished = 1;
        end
      end
    end else if (md) begin
      if (st) begin m_in_seq = 1; m_slot = 0; end
    end else if (acc) begin
      if (int'(sl) < N) begin
        m_chan[sl] = d;
        m_strobe[sl] = 1'b1;
      end else begin
        m_err = 1;
      end
    end
    check_outputs(ph);
  endtask

  // Reset raised between edges must clear everything before the next edge.
  task automatic mid_reset(input string ph);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs({ph, "_rst"});
    check({ph, "_rst_ready"}, DW'(din_ready), '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [DW-1:0] a5;

  initial begin
    rst = 1'b1; mode = 0; start = 0; din_valid = 0; sel = '0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("por");
    check("por_ready", DW'(din_ready), '0);
    @(negedge clk);
    rst = 1'b0;

    // fill some channels so the reset check below has nonzero data to clear
    for (int i = 0; i < N; i++) cycle("fill", 0, 0, 1, SW'(i), rnd_word());
    mid_reset("r1");

    a5 = {16{8'hA5}};
    cycle("man7", 0, 0, 1, 4'd7, a5);
    cycle("man7_idle", 0, 0, 0, 4'd7, '0);
    cycle("man12", 0, 0, 1, 4'd12, rnd_word());
    cycle("man12_idle", 0, 1, 0, 4'd0, '0);

    // full back-to-back auto sequence
    cycle("auto_start", 1, 1, 0, '0, '0);
    for (int i = 0; i < N; i++) cycle("auto", 0, 1, 1, 4'd15, DW'(i));
    cycle("auto_done", 1, 0, 0, '0, '0);
    cycle("auto_idle", 1, 0, 1, '0, '0);

    // stall after beat 3
    cycle("stall_start", 1, 1, 0, '0, '0);
    for (int i = 0; i < 3; i++) cycle("stall_pre", 1, 0, 1, '0, rnd_word());
    for (int i = 0; i < 5; i++) cycle("stall_hold", 0, 1, 0, 4'd2, rnd_word());
    for (int i = 3; i < N; i++) cycle("stall_post", 0, 0, 1, '0, rnd_word());
    cycle("stall_done", 0, 0, 1, '0, rnd_word());

    // reset after beat 6, then a fresh sequence
    cycle("abort_start", 1, 1, 0, '0, '0);
    for (int i = 0; i < 6; i++) cycle("abort_pre", 1, 0, 1, '0, rnd_word());
    mid_reset("abort");
    cycle("restart", 1, 1, 0, '0, '0);
    for (int i = 0; i < 2; i++) cycle("restart_beat", 1, 0, 1, '0, rnd_word());

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) mid_reset("rnd");
      cycle("rnd", $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, SW'($urandom_range(0, 15)), rnd_word());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
